sysid_ext: RTL and testbench
============================

SYSID_EXT -- requirements
Module: sysid_ext

Interface
REQ-001 SHALL expose parameter SYSTEM_ID, default 32'h1B0D_0E1C, value returned at word 0.
REQ-002 SHALL expose parameter BUILD_TS, default 32'h56F4_7CAF, value returned at word 1 (build timestamp, seconds).
REQ-003 SHALL expose parameter VERSION, default 32'h0001_0000, value returned at word 2 ({major[31:16], minor[15:0]}).
REQ-004 SHALL expose parameter CAPS, default 32'h0000_0000, value returned at word 3 (feature bitmap).
REQ-005 SHALL expose parameter CLK_HZ, default 50_000_000, clock frequency used for the seconds prescaler; legal range 2..2^32-1.
REQ-006 SHALL expose parameter ADDR_W, default 3, word-address width; legal range 3..8.
REQ-007 clk  in  1  sole clock; all logic on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 address  in  ADDR_W  word address of the Avalon-MM slave.
REQ-010 read  in  1  read strobe, single-cycle request.
REQ-011 write  in  1  write strobe, single-cycle request.
REQ-012 writedata  in  32  write data.
REQ-013 byteenable  in  4  byte lanes for writes.
REQ-014 readdata  out  32  registered read data.
REQ-015 readdatavalid  out  1  one-cycle pulse qualifying readdata.
REQ-016 tick_1hz  out  1  one-cycle pulse once per second.

Function
REQ-017 Register map SHALL be: 0 ID, 1 TS, 2 VERSION, 3 CAPS (all RO constants), 4 SCRATCH (RW), 5 UPTIME_LO (RO), 6 UPTIME_HI (RO snapshot), 7 SECONDS (RO); addresses >= 8 SHALL read 0.
REQ-018 Read latency SHALL be exactly 1: read at cycle N -> readdatavalid=1 and readdata valid at N+1; no waitrequest; back-to-back reads every cycle SHALL be accepted.
REQ-019 readdata SHALL hold its last value when readdatavalid=0.
REQ-020 Writes SHALL affect only SCRATCH, per byte lane per byteenable; writes to every other address SHALL be ignored without side effect.
REQ-021 read and write asserted together SHALL perform both; the read returns the pre-write SCRATCH value.
REQ-022 Uptime SHALL be a 64-bit free-running cycle counter incremented every cycle, wrapping 2^64-1 -> 0.
REQ-023 A read of UPTIME_LO SHALL return counter[31:0] and, in the same cycle, latch counter[63:32] into the HI snapshot; a read of UPTIME_HI SHALL return the snapshot, giving a coherent 64-bit pair when read LO then HI.
REQ-024 Prescaler SHALL count 0..CLK_HZ-1; on the cycle it wraps to 0, tick_1hz SHALL pulse and SECONDS SHALL increment, wrapping 2^32-1 -> 0.
REQ-025 tick_1hz SHALL be registered; first pulse SHALL occur CLK_HZ cycles after reset deasserts.

Reset
REQ-026 While reset=1: readdata=0, readdatavalid=0, tick_1hz=0, SCRATCH=0, uptime=0, HI snapshot=0, prescaler=0, SECONDS=0.
REQ-027 A read or write presented during reset SHALL be dropped; no readdatavalid SHALL follow it.
REQ-028 Reset asserted in the cycle after a read SHALL suppress that read's readdatavalid.

Structure
REQ-029 Package sysid_pkg SHALL hold the register-offset constants (ID..SECONDS) and the address-decode width constant.
REQ-030 The seconds prescaler and its counter SHALL be a sub-module sysid_tick_div, parameterised by CLK_HZ, with outputs tick and seconds[31:0].
REQ-031 Read mux, SCRATCH, uptime and snapshot SHALL reside in sysid_ext; no latches, no multi-cycle paths.

Verification
REQ-032 Reset, then read addresses 0..3 back-to-back -> readdatavalid at cycles 1..4 with 32'h1B0D_0E1C, 32'h56F4_7CAF, 32'h0001_0000, 32'h0.
REQ-033 Write 32'hDEAD_BEEF, byteenable 4'b0101, to address 4, then read it -> 32'h00AD_00EF; write to address 0, then read it -> still 32'h1B0D_0E1C.
REQ-034 Force uptime to 64'h0000_0001_FFFF_FFFF, read LO, then read HI two cycles later -> LO=32'hFFFF_FFFF, HI=32'h0000_0001 (not 2).
REQ-035 CLK_HZ=10: after reset, tick_1hz pulses at cycles 10, 20, 30; read SECONDS after the third pulse -> 3.
REQ-036 Read address 4 and assert reset in the next cycle -> no readdatavalid; subsequent read of address 4 -> 0.
REQ-037 Read address 9 with ADDR_W=4 -> readdata=0, readdatavalid=1 one cycle later.

Source files
------------

// File: rtl/sysid_pkg.sv
// -----------------------------------------------------------------------------
// sysid_pkg
// Shared constants for the system-ID block: the word offsets of the register
// map and the width of the in-map part of the word address.
// -----------------------------------------------------------------------------
package sysid_pkg;

   // Only the low DEC_W address bits select a register; any set bit above
   // them means the access falls outside the map.
   localparam int DEC_W = 3;

   localparam logic [DEC_W-1:0] REG_ID        = 3'd0;
   localparam logic [DEC_W-1:0] REG_TS        = 3'd1;
   localparam logic [DEC_W-1:0] REG_VERSION   = 3'd2;
   localparam logic [DEC_W-1:0] REG_CAPS      = 3'd3;
   localparam logic [DEC_W-1:0] REG_SCRATCH   = 3'd4;
   localparam logic [DEC_W-1:0] REG_UPTIME_LO = 3'd5;
   localparam logic [DEC_W-1:0] REG_UPTIME_HI = 3'd6;
   localparam logic [DEC_W-1:0] REG_SECONDS   = 3'd7;

endpackage

// File: rtl/sysid_ext_if.sv
// -----------------------------------------------------------------------------
// sysid_ext_if
// Avalon-MM slave bus of the system-ID block.
//   address        word address (ADDR_W bits)
//   read / write   single-cycle request strobes
//   writedata      write data, byteenable selects the lanes written
//   readdata       registered read data
//   readdatavalid  one-cycle pulse qualifying readdata
// -----------------------------------------------------------------------------
interface sysid_ext_if #(
   parameter int ADDR_W = 3
) ();
   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [31:0]       writedata;
   logic [3:0]        byteenable;
   logic [31:0]       readdata;
   logic              readdatavalid;

   modport master (
      output address, read, write, writedata, byteenable,
      input  readdata, readdatavalid
   );

   modport slave (
      input  address, read, write, writedata, byteenable,
      output readdata, readdatavalid
   );
endinterface

// File: rtl/sysid_tick_div.sv
// -----------------------------------------------------------------------------
// sysid_tick_div
// Seconds prescaler: counts clock cycles 0..CLK_HZ-1 and, on the cycle the
// count wraps, pulses tick for one cycle and advances the seconds counter.
//   clk      clock
//   reset    synchronous active-high reset
//   tick     registered one-cycle pulse, first one CLK_HZ cycles after reset
//   seconds  elapsed whole seconds, wraps at 2^32
// -----------------------------------------------------------------------------
module sysid_tick_div #(
   parameter logic [31:0] CLK_HZ = 32'd50_000_000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        tick,
   output logic [31:0] seconds
);

   localparam logic [31:0] LAST = CLK_HZ - 32'd1;

   logic [31:0] presc_q, presc_d;
   logic [31:0] sec_q, sec_d;
   logic        tick_q, tick_d;
   logic        wrap;

   always_comb begin
      wrap    = (presc_q == LAST);
      presc_d = wrap ? 32'd0 : presc_q + 32'd1;
      sec_d   = wrap ? sec_q + 32'd1 : sec_q;
      tick_d  = wrap;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q <= 32'd0;
         sec_q   <= 32'd0;
         tick_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         sec_q   <= sec_d;
         tick_q  <= tick_d;
      end
   end

   assign tick    = tick_q;
   assign seconds = sec_q;

endmodule

// File: rtl/sysid_ext.sv
// -----------------------------------------------------------------------------
// sysid_ext
// System identification register block on an Avalon-MM slave.
// Map: 0 ID, 1 TS, 2 VERSION, 3 CAPS (constants), 4 SCRATCH (RW, byte lanes),
//      5 UPTIME_LO, 6 UPTIME_HI (snapshot taken on LO read), 7 SECONDS.
//      Addresses >= 8 read 0 and ignore writes.
//   clk       clock
//   reset     synchronous active-high reset
//   bus       Avalon-MM slave (sysid_ext_if.slave), read latency 1
//   tick_1hz  one-cycle pulse once per second
// -----------------------------------------------------------------------------
module sysid_ext
   import sysid_pkg::*;
#(
   parameter logic [31:0] SYSTEM_ID = 32'h1B0D_0E1C,
   parameter logic [31:0] BUILD_TS  = 32'h56F4_7CAF,
   parameter logic [31:0] VERSION   = 32'h0001_0000,
   parameter logic [31:0] CAPS      = 32'h0000_0000,
   parameter logic [31:0] CLK_HZ    = 32'd50_000_000,
   parameter int          ADDR_W    = 3
) (
   input  logic        clk,
   input  logic        reset,
   sysid_ext_if.slave  bus,
   output logic        tick_1hz
);

   logic [7:0]       addr8;
   logic             in_map;
   logic [DEC_W-1:0] sel;
   logic             rd_en;
   logic             wr_en;
   logic [31:0]      rd_mux;
   logic [31:0]      seconds;

   logic [31:0] scratch_q, scratch_d;
   logic [63:0] uptime_q, uptime_d;
   logic [31:0] snap_q, snap_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rdv_q, rdv_d;

   sysid_tick_div #(.CLK_HZ(CLK_HZ)) u_tick_div (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick_1hz),
      .seconds (seconds)
   );

   // Widen to the largest legal address so the out-of-map test is uniform
   // across ADDR_W values.
   assign addr8  = 8'(bus.address);
   assign in_map = (addr8[7:DEC_W] == '0);
   assign sel    = addr8[DEC_W-1:0];
   assign rd_en  = bus.read & ~reset;
   assign wr_en  = bus.write & ~reset & in_map & (sel == REG_SCRATCH);

   always_comb begin
      rd_mux = 32'd0;
      if (in_map) begin
         case (sel)
            REG_ID:        rd_mux = SYSTEM_ID;
            REG_TS:        rd_mux = BUILD_TS;
            REG_VERSION:   rd_mux = VERSION;
            REG_CAPS:      rd_mux = CAPS;
            REG_SCRATCH:   rd_mux = scratch_q;
            REG_UPTIME_LO: rd_mux = uptime_q[31:0];
            REG_UPTIME_HI: rd_mux = snap_q;
            REG_SECONDS:   rd_mux = seconds;
            default:       rd_mux = 32'd0;
         endcase
      end
   end

   // The mux reads scratch_q, so a simultaneous read returns the old value.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign scratch_d[gi*8 +: 8] = (wr_en & bus.byteenable[gi])
                                     ? bus.writedata[gi*8 +: 8]
                                     : scratch_q[gi*8 +: 8];
      end
   endgenerate

   always_comb begin
      uptime_d = uptime_q + 64'd1;
      // The high half is frozen in the same cycle LO is returned so a LO/HI
      // read pair is coherent even across a carry out of the low word.
      snap_d   = (rd_en && in_map && sel == REG_UPTIME_LO) ? uptime_q[63:32] : snap_q;
      rdata_d  = rd_en ? rd_mux : rdata_q;
      rdv_d    = rd_en;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         scratch_q <= 32'd0;
         uptime_q  <= 64'd0;
         snap_q    <= 32'd0;
         rdata_q   <= 32'd0;
         rdv_q     <= 1'b0;
      end else begin
         scratch_q <= scratch_d;
         uptime_q  <= uptime_d;
         snap_q    <= snap_d;
         rdata_q   <= rdata_d;
         rdv_q     <= rdv_d;
      end
   end

   // Gating with reset drops the response of a read whose data phase
   // coincides with reset being raised.
   assign bus.readdata      = rdata_q;
   assign bus.readdatavalid = rdv_q & ~reset;

endmodule

// File: tb/tb_sysid_ext.sv
// -----------------------------------------------------------------------------
// tb_sysid_ext
// Directed testbench for sysid_ext (CLK_HZ=10, ADDR_W=4, default constants).
// -----------------------------------------------------------------------------
module tb_sysid_ext;

   logic clk = 1'b0;
   logic reset;
   logic tick_1hz;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int tick_log[$];

   sysid_ext_if #(.ADDR_W(4)) bus ();

   sysid_ext #(
      .CLK_HZ (32'd10),
      .ADDR_W (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .tick_1hz (tick_1hz)
   );

   always #5 clk = ~clk;

   // cyc = number of rising edges seen with reset low since the last reset
   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (!reset && tick_1hz) tick_log.push_back(cyc);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
      bus.address    = addr;
      bus.writedata  = data;
      bus.byteenable = be;
      bus.write      = 1'b1;
      @(negedge clk);
      bus.write      = 1'b0;
   endtask

   task automatic do_read(input logic [3:0] addr, input logic [31:0] exp, input string tag);
      bus.address = addr;
      bus.read    = 1'b1;
      @(negedge clk);
      bus.read    = 1'b0;
      check({tag, "_rdv"}, 64'(bus.readdatavalid), 64'd1);
      check(tag, 64'(bus.readdata), 64'(exp));
   endtask

   logic [31:0] exp_const [4];

   initial begin
      int guard;
      exp_const[0] = 32'h1B0D_0E1C;
      exp_const[1] = 32'h56F4_7CAF;
      exp_const[2] = 32'h0001_0000;
      exp_const[3] = 32'h0000_0000;

      reset          = 1'b1;
      bus.address    = '0;
      bus.read       = 1'b0;
      bus.write      = 1'b0;
      bus.writedata  = '0;
      bus.byteenable = '0;
      repeat (3) @(negedge clk);
      check("rst_rdata", 64'(bus.readdata), 64'd0);
      check("rst_rdv", 64'(bus.readdatavalid), 64'd0);
      check("rst_tick", 64'(tick_1hz), 64'd0);

      // Requests presented during reset must vanish
      bus.address    = 4'd4;
      bus.read       = 1'b1;
      bus.write      = 1'b1;
      bus.writedata  = 32'hFFFF_FFFF;
      bus.byteenable = 4'hF;
      @(negedge clk);
      check("rst_read_rdv", 64'(bus.readdatavalid), 64'd0);
      reset     = 1'b0;
      bus.read  = 1'b0;
      bus.write = 1'b0;
      @(negedge clk);
      check("rst_read_dropped", 64'(bus.readdatavalid), 64'd0);

      // Back-to-back reads of the constant words
      for (int i = 0; i < 4; i++) begin
         bus.address = 4'(i);
         bus.read    = 1'b1;
         @(negedge clk);
         check($sformatf("b2b_rdv%0d", i), 64'(bus.readdatavalid), 64'd1);
         check($sformatf("b2b_word%0d", i), 64'(bus.readdata), 64'(exp_const[i]));
      end
      bus.read = 1'b0;
      do_read(4'd1, 32'h56F4_7CAF, "ts");
      @(negedge clk);
      check("hold_rdv", 64'(bus.readdatavalid), 64'd0);
      check("hold_data", 64'(bus.readdata), 64'h56F4_7CAF);

      do_read(4'd4, 32'h0, "scratch_rst");
      do_read(4'd6, 32'h0, "hi_rst");

      // Byte-lane write, write to RO word, aliased out-of-map write
      do_write(4'd4, 32'hDEAD_BEEF, 4'b0101);
      do_read(4'd4, 32'h00AD_00EF, "scratch_be");
      do_write(4'd0, 32'h1234_5678, 4'hF);
      do_read(4'd0, 32'h1B0D_0E1C, "id_ro");
      do_write(4'd12, 32'hFFFF_FFFF, 4'hF);
      do_read(4'd4, 32'h00AD_00EF, "scratch_alias");
      do_read(4'd9, 32'h0, "oob_9");

      // Simultaneous read and write returns the pre-write value
      bus.address    = 4'd4;
      bus.writedata  = 32'h1234_5678;
      bus.byteenable = 4'hF;
      bus.read       = 1'b1;
      bus.write      = 1'b1;
      @(negedge clk);
      bus.read  = 1'b0;
      bus.write = 1'b0;
      check("rw_rdv", 64'(bus.readdatavalid), 64'd1);
      check("rw_old", 64'(bus.readdata), 64'h00AD_00EF);
      do_read(4'd4, 32'h1234_5678, "rw_new");

      // Coherent uptime pair across a low-word carry
      bus.address = 4'd5;
      bus.read    = 1'b1;
      force dut.uptime_q = 64'h0000_0001_FFFF_FFFF;
      @(posedge clk);
      #1;
      release dut.uptime_q;
      bus.read = 1'b0;
      @(negedge clk);
      check("up_lo_rdv", 64'(bus.readdatavalid), 64'd1);
      check("up_lo", 64'(bus.readdata), 64'hFFFF_FFFF);
      @(negedge clk);
      do_read(4'd6, 32'h0000_0001, "up_hi");

      // Seconds after the third tick
      guard = 0;
      while (cyc < 31 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check("wait_tick3_timeout", 64'(guard < 200), 64'd1);
      do_read(4'd7, 32'd3, "seconds");
      check("tick_count", 64'(tick_log.size()), 64'd3);
      for (int i = 0; i < 3; i++) begin
         if (i < tick_log.size())
            check($sformatf("tick_at%0d", i), 64'(tick_log[i]), 64'(10 * (i + 1)));
      end

      // Reset in the data phase kills the response
      bus.address = 4'd4;
      bus.read    = 1'b1;
      @(negedge clk);
      bus.read = 1'b0;
      reset    = 1'b1;
      #1;
      check("rst_kill_rdv", 64'(bus.readdatavalid), 64'd0);
      @(negedge clk);
      check("rst2_rdv", 64'(bus.readdatavalid), 64'd0);
      check("rst2_rdata", 64'(bus.readdata), 64'd0);
      check("rst2_tick", 64'(tick_1hz), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      check("rst2_no_late_rdv", 64'(bus.readdatavalid), 64'd0);
      do_read(4'd4, 32'h0, "scratch_rst2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
